// File: rtl/mult_seq_ctrl.sv
// Iterative WIDTH x WIDTH shift-add multiplier with sign fix-up and START/BUSY/DONE handshake.
// Optional overflow flag output OVF is enabled by defining MULT_OVF_EN.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
`ifdef MULT_OVF_EN
  output logic             OVF,
`endif
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MULT_OVF_EN
  logic               signed_q;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: state_n gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (START) state_n = PREP;
      PREP: state_n = RUN;
      RUN:  if (cnt == LAST_ITER) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The WIDTH+1-bit add keeps the carry; the shift below brings it into the top of acc_hi.
  assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_fix = neg ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
  assign BUSY     = (state != IDLE);

  // NOTE: datapath registers are plain flops, so all of them take the reset value explicitly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      DONE   <= 1'b0;
`ifdef MULT_OVF_EN
      signed_q <= 1'b0;
      OVF      <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: if (START) begin
          mcand  <= (SIGNED && A[WIDTH-1]) ? (~A + 1'b1) : A;
          mplier <= (SIGNED && B[WIDTH-1]) ? (~B + 1'b1) : B;
          neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULT_OVF_EN
          signed_q <= SIGNED;
`endif
        end
        PREP: begin
          acc_hi <= '0;
          acc_lo <= mplier;
          cnt    <= '0;
        end
        RUN: begin
          acc_hi <= add_sum[WIDTH:1];
          acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          HI   <= prod_fix[2*WIDTH-1:WIDTH];
          LO   <= prod_fix[WIDTH-1:0];
          DONE <= 1'b1;
`ifdef MULT_OVF_EN
          OVF  <= signed_q ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                           : (prod_fix[2*WIDTH-1:WIDTH] != '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed products, busy/back-to-back handshake, reset abort.
// Define MULT_OVF_EN for both bench and RTL to also check the OVF output.
module tb_mult_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        BUSY, DONE;
  logic [31:0] HI, LO;
`ifdef MULT_OVF_EN
  logic        OVF;
`endif

  mult_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SIGNED(SIGNED), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .HI(HI),
`ifdef MULT_OVF_EN
    .OVF(OVF),
`endif
    .LO(LO)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   start_edge = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic ovf_of(input logic s, input logic [63:0] p);
    return s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'b0);
  endfunction

  // Called at a negedge; the following posedge samples START and the operands.
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_prod, input bit push);
    exp_t e;
    START = 1'b1; SIGNED = s; A = a; B = b;
    @(negedge CLK);
    start_edge = edge_cnt;
    START = 1'b0; A = $urandom; B = $urandom; SIGNED = ~s;
    if (push) begin
      e.prod = exp_prod;
      e.ovf  = ovf_of(s, exp_prod);
      sb.push_back(e);
    end
  endtask

  // Returns at the negedge of the DONE cycle.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (DONE !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done"}, 64'(DONE), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_has_entry"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    if (DONE !== 1'b1) return;
    check({tag, "_latency"}, 64'(edge_cnt - start_edge), 64'd34);
    check({tag, "_busy"}, 64'(BUSY), 64'd0);
    check({tag, "_prod"}, {HI, LO}, e.prod);
`ifdef MULT_OVF_EN
    check({tag, "_ovf"}, 64'(OVF), 64'(e.ovf));
`endif
  endtask

  initial begin
    int   dones;
    logic [31:0] ra, rb;

    // Reset state
    #1;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
`ifdef MULT_OVF_EN
    check("rst_ovf", 64'(OVF), 64'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Full-scale unsigned and signed boundaries
    do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
    check("busy_after_start", 64'(BUSY), 64'd1);
    wait_done("u_max");
    @(negedge CLK);
    check("done_pulse_one_cycle", 64'(DONE), 64'd0);
    do_start(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1);
    wait_done("s_m3x7");
    do_start(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
    wait_done("s_minxmin");
    do_start(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
    wait_done("u_8x8");
    do_start(1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0, 1);
    wait_done("s_zero");
    do_start(1'b1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1);
    wait_done("s_ovf1");
    do_start(1'b1, 32'h0000_0002, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 1);
    wait_done("s_2xm3");

    // START while BUSY is ignored; START in the DONE cycle is accepted
    do_start(1'b0, 32'd5, 32'd6, 64'd30, 1);
    repeat (3) @(negedge CLK);
    START = 1'b1; A = 32'd9; B = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    wait_done("busy_ignore");
    do_start(1'b0, 32'd2, 32'd3, 64'd6, 1);
    wait_done("back_to_back");

    // Reset mid-RUN aborts the operation
    do_start(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 0);
    repeat (10) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    #1 RESET = 1'b0;
    dones = 0;
    repeat (45) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    do_start(1'b1, 32'hFFFF_FFF9, 32'h0000_0100, model(1'b1, 32'hFFFF_FFF9, 32'h0000_0100), 1);
    wait_done("after_abort");

    // Random operands against the reference model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_start(i[0], ra, rb, model(i[0], ra, rb), 1);
      wait_done("rand");
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
